compute_engine_sequencer: RTL and testbench
===========================================

// Module: compute_engine_sequencer
// PURPOSE
//  Parametrised successor to the fixed 3-way computation wrapper. Owns the one shared
//  scratch memory port for N_ENG compute engines (serial, systolic, custom, ...).
//  Sequences a single engine run per start request: enable, port ownership, result
//  capture, cycle count and a done pulse back to the top-level FSM.
//  Unselected engines never see memory data and never drive the write-enable.
// PARAMETERS
//  N_ENG     3   number of attached engines (2..8)
//  ADDR_W    6   memory address width
//  DATA_W    8   memory / result data width
//  N_RES     4   result words per engine (c11,c12,c21,c22)
//  CNT_W     16  width of run cycle counter
//  TMO_CYC   1024 watchdog limit in RUN cycles (used only with CES_TIMEOUT_EN)
// PORTS
//  clk        in   1                  clock, all state on rising edge
//  rst        in   1                  synchronous, active-high reset
//  start      in   1                  run request, sampled in IDLE only
//  mode_sel   in   clog2(N_ENG)       engine index, latched on accepted start
//  busy       out  1                  high in RUN and DONE
//  done       out  1                  one-cycle pulse in DONE
//  sel_err    out  1                  sticky: start with mode_sel>=N_ENG; cleared by next accepted start
//  eng_en     out  N_ENG              level enable, one-hot on latched engine during RUN
//  eng_done   in   N_ENG              engine completion flags
//  eng_addr   in   N_ENG*ADDR_W       packed engine addresses, engine k at [k*ADDR_W +: ADDR_W]
//  eng_we     in   N_ENG              engine write enables
//  eng_res    in   N_ENG*N_RES*DATA_W packed engine results
//  eng_q      out  N_ENG*DATA_W       memory read data routed to engines
//  mem_addr   out  ADDR_W             shared memory address
//  mem_we     out  1                  shared memory write enable
//  mem_q      in   DATA_W             shared memory read data
//  res_o      out  N_RES*DATA_W       captured results of last run
//  res_valid  out  1                  res_o holds a completed run
//  cycles_o   out  CNT_W              RUN-cycle count of last/current run
//  tmo_err    out  1                  watchdog fired (0 without CES_TIMEOUT_EN)
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE; busy,done,eng_en,res_valid,sel_err,tmo_err=0;
//   res_o=0; cycles_o=0; sel=0. Reset mid-run aborts at once: eng_en drops next edge.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: start=1 & mode_sel<N_ENG -> latch sel, cycles_o<=0, res_valid<=0, sel_err<=0, -> RUN.
//         start=1 & mode_sel>=N_ENG -> sel_err<=1, stay IDLE.
//   RUN:  eng_en[sel]=1; cycles_o increments each RUN cycle (saturates at all-ones).
//         eng_done[sel]=1 -> res_o<=eng_res[sel], res_valid<=1, -> DONE; that cycle is counted.
//         eng_done of other engines ignored.
//   DONE: done=1, eng_en=0, one cycle, -> IDLE. start here is ignored (not queued).
//  Latency: start sampled at edge t -> eng_en high from t+1; eng_done seen at edge d
//   -> done high in cycle d+1; earliest next start accepted at edge d+2.
//  start while busy: ignored, no effect on sel or counters.
//  Port routing (combinational from registered sel/state):
//   RUN:   mem_addr=eng_addr[sel]; mem_we=eng_we[sel]; eng_q[sel]=mem_q, other lanes 0.
//   IDLE/DONE: mem_addr=0, mem_we=0, all eng_q lanes 0.
//  res_o and cycles_o hold until next accepted start.
// CONFIGURATION
//  CES_TIMEOUT_EN defined: in RUN, when cycles_o reaches TMO_CYC-1 without eng_done[sel],
//   go to DONE with tmo_err<=1, res_valid stays 0, res_o unchanged; tmo_err cleared on
//   next accepted start. eng_done on the limit cycle wins over timeout.
//  Undefined: no watchdog logic, tmo_err tied 0, RUN waits indefinitely.
// TESTING
//  1 N_ENG=3: start,mode_sel=1; engine1 done after 5 RUN cycles with res={8'h11,8'h22,8'h33,8'h44}
//    -> eng_en=3'b010 cycles t+1..t+5, done pulse at t+6, res_o=32'h11223344, cycles_o=5.
//  2 RUN sel=2, eng_we=3'b011, eng_addr2=6'd9, mem_q=8'hA5 -> mem_we=0, mem_addr=9,
//    eng_q lane2=A5, lanes0/1=0; IDLE -> mem_we=0, mem_addr=0.
//  3 start,mode_sel=3 (N_ENG=3) -> sel_err=1, stays IDLE, eng_en=0; then valid start clears sel_err.
//  4 start pulsed during RUN and DONE; eng_done[0] while sel=2 -> no restart, no capture.
//  5 rst at 3rd RUN cycle -> next cycle eng_en=0, busy=0, res_valid=0, cycles_o=0.
//  6 CES_TIMEOUT_EN, TMO_CYC=16, engine never done -> done pulse after 16 RUN cycles,
//    tmo_err=1, res_valid=0; without macro busy stays 1 for 100 cycles.

Source files
------------

// File: rtl/compute_engine_sequencer_if.sv
// Bus bundle between the run sequencer and its surroundings: run control,
// per-engine enable/status/memory lanes and the single shared scratch memory port.
interface compute_engine_sequencer_if #(
  parameter int N_ENG  = 3,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int N_RES  = 4,
  parameter int CNT_W  = 16
);
  localparam int SEL_W = (N_ENG > 1) ? $clog2(N_ENG) : 1;

  logic                          start;
  logic [SEL_W-1:0]              mode_sel;
  logic                          busy;
  logic                          done;
  logic                          sel_err;
  logic [N_ENG-1:0]              eng_en;
  logic [N_ENG-1:0]              eng_done;
  logic [N_ENG*ADDR_W-1:0]       eng_addr;
  logic [N_ENG-1:0]              eng_we;
  logic [N_ENG*N_RES*DATA_W-1:0] eng_res;
  logic [N_ENG*DATA_W-1:0]       eng_q;
  logic [ADDR_W-1:0]             mem_addr;
  logic                          mem_we;
  logic [DATA_W-1:0]             mem_q;
  logic [N_RES*DATA_W-1:0]       res_o;
  logic                          res_valid;
  logic [CNT_W-1:0]              cycles_o;
  logic                          tmo_err;

  // Environment side: top-level FSM, engines and the memory.
  modport master (
    output start, mode_sel, eng_done, eng_addr, eng_we, eng_res, mem_q,
    input  busy, done, sel_err, eng_en, eng_q, mem_addr, mem_we,
           res_o, res_valid, cycles_o, tmo_err
  );

  // Sequencer side.
  modport slave (
    input  start, mode_sel, eng_done, eng_addr, eng_we, eng_res, mem_q,
    output busy, done, sel_err, eng_en, eng_q, mem_addr, mem_we,
           res_o, res_valid, cycles_o, tmo_err
  );
endinterface

// File: rtl/compute_engine_sequencer.sv
// Single-run sequencer owning the shared scratch memory port for N_ENG engines.
// Optional watchdog on the RUN phase is enabled by defining CES_TIMEOUT_EN.
module compute_engine_sequencer #(
  parameter int N_ENG   = 3,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 8,
  parameter int N_RES   = 4,
  parameter int CNT_W   = 16,
  parameter int TMO_CYC = 1024
) (
  input logic                        clk,
  input logic                        rst,
  compute_engine_sequencer_if.slave  bus
);
  localparam int SEL_W = (N_ENG > 1) ? $clog2(N_ENG) : 1;
  localparam int RES_W = N_RES * DATA_W;

  if (N_ENG < 2 || N_ENG > 8 || TMO_CYC < 2) begin : g_param_check
    $error("compute_engine_sequencer: N_ENG must be 2..8 and TMO_CYC at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic               res_valid_q, res_valid_d;
  logic               sel_err_q, sel_err_d;
`ifdef CES_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TMO_CYC - 1);
  logic               tmo_err_q, tmo_err_d;
`endif

  logic [N_ENG-1:0]        eng_en_c;
  logic [N_ENG*DATA_W-1:0] eng_q_c;
  logic [ADDR_W-1:0]       mem_addr_c;
  logic                    mem_we_c;

  // Run-cycle counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      cycles_q    <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
`ifdef CES_TIMEOUT_EN
      tmo_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cycles_q    <= cycles_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      sel_err_q   <= sel_err_d;
`ifdef CES_TIMEOUT_EN
      tmo_err_q   <= tmo_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cycles_d    = cycles_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    sel_err_d   = sel_err_q;
`ifdef CES_TIMEOUT_EN
    tmo_err_d   = tmo_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (int'(bus.mode_sel) < N_ENG) begin
            sel_d       = bus.mode_sel;
            cycles_d    = '0;
            res_valid_d = 1'b0;
            sel_err_d   = 1'b0;
`ifdef CES_TIMEOUT_EN
            tmo_err_d   = 1'b0;
`endif
            state_d     = S_RUN;
          end else begin
            sel_err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        // The completing cycle is itself counted; a completion on the limit cycle beats the watchdog.
        cycles_d = sat_inc(cycles_q);
        if (bus.eng_done[sel_q]) begin
          res_d       = bus.eng_res[int'(sel_q)*RES_W +: RES_W];
          res_valid_d = 1'b1;
          state_d     = S_DONE;
        end
`ifdef CES_TIMEOUT_EN
        else if (cycles_q == TMO_LIM) begin
          tmo_err_d = 1'b1;
          state_d   = S_DONE;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Only the latched engine sees memory data or reaches the write-enable, and only in RUN.
  always_comb begin
    eng_en_c   = '0;
    eng_q_c    = '0;
    mem_addr_c = '0;
    mem_we_c   = 1'b0;
    if (state_q == S_RUN) begin
      eng_en_c[sel_q]                       = 1'b1;
      eng_q_c[int'(sel_q)*DATA_W +: DATA_W] = bus.mem_q;
      mem_addr_c = bus.eng_addr[int'(sel_q)*ADDR_W +: ADDR_W];
      mem_we_c   = bus.eng_we[sel_q];
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.sel_err   = sel_err_q;
  assign bus.eng_en    = eng_en_c;
  assign bus.eng_q     = eng_q_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.res_o     = res_q;
  assign bus.res_valid = res_valid_q;
  assign bus.cycles_o  = cycles_q;
`ifdef CES_TIMEOUT_EN
  assign bus.tmo_err   = tmo_err_q;
`else
  assign bus.tmo_err   = 1'b0;
`endif
endmodule

// File: tb/tb_compute_engine_sequencer.sv
// Self-checking bench for compute_engine_sequencer: table of engine runs plus
// hand-written corner sequences (select error, ignored starts, reset abort, watchdog).
module tb_compute_engine_sequencer;
  localparam int N_ENG   = 3;
  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 8;
  localparam int N_RES   = 4;
  localparam int CNT_W   = 16;
  localparam int TMO_CYC = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  compute_engine_sequencer_if #(
    .N_ENG(N_ENG), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_RES(N_RES), .CNT_W(CNT_W)
  ) bus ();

  compute_engine_sequencer #(
    .N_ENG(N_ENG), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_RES(N_RES),
    .CNT_W(CNT_W), .TMO_CYC(TMO_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          sel;
    int          len;
    logic [31:0] res;
    logic [5:0]  addr;
    logic [2:0]  we;
    logic [7:0]  q;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [15:0] cyc;
  } exp_t;

  vec_t vecs[5];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Selected lane gets the vector's values, other lanes get decoys.
  task automatic drive_lanes(input vec_t v);
    for (int k = 0; k < N_ENG; k++) begin
      bus.eng_res[k*32 +: 32] = (k == v.sel) ? v.res : (~v.res ^ 32'(k));
      bus.eng_addr[k*6 +: 6]  = (k == v.sel) ? v.addr : ~v.addr;
    end
    bus.eng_we = v.we;
    bus.mem_q  = v.q;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    exp_t        e;
    logic [23:0] eq;
    logic [2:0]  onehot;
    logic [31:0] held;
    int          w;
    drive_lanes(v);
    onehot = 3'b001 << v.sel;
    eq = '0;
    eq[v.sel*8 +: 8] = v.q;
    bus.start    = 1'b1;
    bus.mode_sel = 2'(v.sel);
    sb.push_back('{v.res, 16'(v.len)});
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= v.len; k++) begin
      check($sformatf("v%0d_eng_en_c%0d", i, k), bus.eng_en, onehot);
      if (k == 1) begin
        check($sformatf("v%0d_busy", i), bus.busy, 1'b1);
        check($sformatf("v%0d_done_low", i), bus.done, 1'b0);
        check($sformatf("v%0d_mem_addr", i), bus.mem_addr, v.addr);
        check($sformatf("v%0d_mem_we", i), bus.mem_we, v.we[v.sel]);
        check($sformatf("v%0d_eng_q", i), bus.eng_q, eq);
        check($sformatf("v%0d_rv_cleared", i), bus.res_valid, 1'b0);
      end
      if (k == v.len) bus.eng_done = onehot;
      tick();
    end
    bus.eng_done = '0;
    w = 0;
    while (!bus.done && w < 4) begin
      tick();
      w++;
    end
    check($sformatf("v%0d_done", i), bus.done, 1'b1);
    check($sformatf("v%0d_done_latency", i), 64'(w), 64'd0);
    check($sformatf("v%0d_en_in_done", i), bus.eng_en, 3'b000);
    check($sformatf("v%0d_busy_in_done", i), bus.busy, 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("v%0d_res_o", i), bus.res_o, e.res);
      check($sformatf("v%0d_cycles_o", i), bus.cycles_o, e.cyc);
      check($sformatf("v%0d_res_valid", i), bus.res_valid, 1'b1);
    end else begin
      n_tests++;
      n_fail++;
      $display("FAIL v%0d_scoreboard: got empty queue, expected one entry", i);
    end
    held = bus.res_o;
    tick();
    check($sformatf("v%0d_idle_busy", i), bus.busy, 1'b0);
    check($sformatf("v%0d_idle_done", i), bus.done, 1'b0);
    check($sformatf("v%0d_idle_addr", i), bus.mem_addr, 6'd0);
    check($sformatf("v%0d_idle_we", i), bus.mem_we, 1'b0);
    check($sformatf("v%0d_idle_eng_q", i), bus.eng_q, 24'd0);
    check($sformatf("v%0d_res_hold", i), bus.res_o, v.res);
    check($sformatf("v%0d_res_hold_reg", i), bus.res_o, held);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int          cnt;
    logic [31:0] prev_res;

    vecs[0] = '{1, 5, 32'h11223344, 6'd4,  3'b010, 8'h3C};
    vecs[1] = '{2, 3, 32'hDEADBEEF, 6'd9,  3'b011, 8'hA5};
    vecs[2] = '{0, 1, 32'hCAFE0001, 6'd63, 3'b001, 8'hFF};
    vecs[3] = '{2, 7, 32'h80808080, 6'd0,  3'b100, 8'h01};
    vecs[4] = '{1, 2, 32'h5A5AA5A5, 6'd33, 3'b101, 8'h7E};

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.mode_sel = '0;
    bus.eng_done = '0;
    bus.eng_addr = '0;
    bus.eng_we   = '0;
    bus.eng_res  = '0;
    bus.mem_q    = '0;
    tick();
    tick();
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_eng_en", bus.eng_en, 3'b000);
    check("rst_res_valid", bus.res_valid, 1'b0);
    check("rst_sel_err", bus.sel_err, 1'b0);
    check("rst_tmo_err", bus.tmo_err, 1'b0);
    check("rst_res_o", bus.res_o, 32'd0);
    check("rst_cycles_o", bus.cycles_o, 16'd0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Out-of-range select: flagged, no run; cleared by the next accepted start.
    bus.start    = 1'b1;
    bus.mode_sel = 2'd3;
    tick();
    bus.start = 1'b0;
    check("selerr_set", bus.sel_err, 1'b1);
    check("selerr_busy", bus.busy, 1'b0);
    check("selerr_eng_en", bus.eng_en, 3'b000);
    tick();
    check("selerr_sticky", bus.sel_err, 1'b1);
    drive_lanes(vecs[2]);
    bus.start    = 1'b1;
    bus.mode_sel = 2'd0;
    tick();
    bus.start = 1'b0;
    check("selerr_cleared", bus.sel_err, 1'b0);
    check("selerr_run_en", bus.eng_en, 3'b001);
    bus.eng_done = 3'b001;
    tick();
    bus.eng_done = '0;
    check("selerr_run_done", bus.done, 1'b1);
    tick();

    // Starts during RUN/DONE and a foreign eng_done must not disturb the run on engine 2.
    drive_lanes('{2, 4, 32'hA1B2C3D4, 6'd17, 3'b001, 8'h5C});
    bus.start    = 1'b1;
    bus.mode_sel = 2'd2;
    tick();
    bus.mode_sel = 2'd0;
    bus.eng_done = 3'b001;
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("ign_busy_c%0d", k), bus.busy, 1'b1);
      check($sformatf("ign_en_c%0d", k), bus.eng_en, 3'b100);
      check($sformatf("ign_rv_c%0d", k), bus.res_valid, 1'b0);
      tick();
    end
    bus.eng_done = 3'b100;
    tick();
    bus.eng_done = '0;
    check("ign_done", bus.done, 1'b1);
    tick();
    bus.start = 1'b0;
    check("ign_no_requeue", bus.busy, 1'b0);
    check("ign_res_o", bus.res_o, 32'hA1B2C3D4);
    check("ign_cycles_o", bus.cycles_o, 16'd4);
    tick();
    check("ign_still_idle", bus.busy, 1'b0);
    prev_res = 32'hA1B2C3D4;

`ifdef CES_TIMEOUT_EN
    // Engine never completes: watchdog ends the run after TMO_CYC RUN cycles.
    drive_lanes(vecs[2]);
    bus.start    = 1'b1;
    bus.mode_sel = 2'd0;
    tick();
    bus.start = 1'b0;
    cnt = 0;
    while (bus.busy && !bus.done && cnt < 40) begin
      if (bus.eng_en != 3'b000) cnt++;
      tick();
    end
    check("tmo_done", bus.done, 1'b1);
    check("tmo_run_cycles", 64'(cnt), 64'(TMO_CYC));
    check("tmo_err_set", bus.tmo_err, 1'b1);
    check("tmo_res_valid", bus.res_valid, 1'b0);
    check("tmo_cycles_o", bus.cycles_o, 16'(TMO_CYC));
    check("tmo_res_unchanged", bus.res_o, prev_res);
    tick();
    // Completion on the limit cycle wins over the watchdog.
    drive_lanes(vecs[4]);
    bus.start    = 1'b1;
    bus.mode_sel = 2'd1;
    tick();
    bus.start = 1'b0;
    check("tmo_err_cleared", bus.tmo_err, 1'b0);
    for (int k = 1; k <= TMO_CYC; k++) begin
      if (k == TMO_CYC) bus.eng_done = 3'b010;
      tick();
    end
    bus.eng_done = '0;
    check("lim_done", bus.done, 1'b1);
    check("lim_res_valid", bus.res_valid, 1'b1);
    check("lim_tmo_err", bus.tmo_err, 1'b0);
    check("lim_res_o", bus.res_o, vecs[4].res);
    check("lim_cycles_o", bus.cycles_o, 16'(TMO_CYC));
    tick();
`else
    // No watchdog: an engine that never completes keeps the sequencer busy.
    drive_lanes(vecs[2]);
    bus.start    = 1'b1;
    bus.mode_sel = 2'd0;
    tick();
    bus.start = 1'b0;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      if (bus.busy && !bus.done) cnt++;
      tick();
    end
    check("notmo_busy_100", 64'(cnt), 64'd100);
    check("notmo_tmo_err", bus.tmo_err, 1'b0);
    check("notmo_cycles_o", bus.cycles_o, 16'd100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("notmo_abort", bus.busy, 1'b0);
    tick();
`endif

    // Reset in the third RUN cycle aborts immediately.
    drive_lanes(vecs[0]);
    bus.start    = 1'b1;
    bus.mode_sel = 2'd1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("abort_run3_en", bus.eng_en, 3'b010);
    check("abort_run3_cycles", bus.cycles_o, 16'd2);
    rst = 1'b1;
    tick();
    check("abort_eng_en", bus.eng_en, 3'b000);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_res_valid", bus.res_valid, 1'b0);
    check("abort_cycles_o", bus.cycles_o, 16'd0);
    check("abort_res_o", bus.res_o, 32'd0);
    check("abort_mem_we", bus.mem_we, 1'b0);
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
